// File: rtl/rx_frame_release_ctrl_if.sv
// Handshake bundle between the rx engine / data FIFO and the frame release controller.
// master = rx engine and FIFO side, slave = rx_frame_release_ctrl.
interface rx_frame_release_ctrl_if;
  logic fifo_wr_en;
  logic frame_end;
  logic crc_done;
  logic crc_good;
  logic fifo_empty;
  logic fifo_rd_en;
  logic rx_out_valid;
  logic rx_good_frame;
  logic rx_bad_frame;
  logic desc_full;
  logic rx_overflow;

  modport master (
    output fifo_wr_en, frame_end, crc_done, crc_good, fifo_empty,
    input  fifo_rd_en, rx_out_valid, rx_good_frame, rx_bad_frame, desc_full, rx_overflow
  );

  modport slave (
    input  fifo_wr_en, frame_end, crc_done, crc_good, fifo_empty,
    output fifo_rd_en, rx_out_valid, rx_good_frame, rx_bad_frame, desc_full, rx_overflow
  );
endinterface

// File: rtl/rx_frame_release_ctrl.sv
// Pairs each frame's word count with its CRC verdict and drains the data FIFO frame by frame.
// Optional macro RX_DROP_BAD_EN: bad frames are read out silently (no rx_out_valid).
module rx_frame_release_ctrl #(
  parameter int unsigned LEN_W   = 11,
  parameter int unsigned DESC_AW = 2
) (
  input logic                    rxclk,
  input logic                    reset,
  rx_frame_release_ctrl_if.slave rx_io
);
  localparam int unsigned Depth = 1 << DESC_AW;
  localparam logic [LEN_W-1:0]   LenMax = '1;
  localparam logic [LEN_W-1:0]   LenOne = LEN_W'(1);
  localparam logic [DESC_AW-1:0] PtrOne = DESC_AW'(1);
  localparam logic [DESC_AW:0]   CntOne = {{DESC_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRead, StDrop} state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   wcnt_q, wcnt_d, rem_q, frame_len;
  logic [LEN_W-1:0]   len_mem_q [Depth];
  logic [Depth-1:0]   stat_mem_q;
  logic [DESC_AW-1:0] len_wp_q, len_rp_q, stat_wp_q, stat_rp_q;
  logic [DESC_AW:0]   len_cnt_q, len_cnt_d, stat_cnt_q, stat_cnt_d;
  logic               cur_good_q, valid_q, good_frame_q, bad_frame_q, ovf_q, ovf_d;
  logic               wsat, len_full, len_push, stat_push, start, rd_en;

  always_comb begin
    wsat      = (wcnt_q == LenMax);
    frame_len = wsat ? LenMax : wcnt_q + LenOne;
    // Count never exceeds Depth, so the MSB is set only when the queue is full.
    len_full  = len_cnt_q[DESC_AW];
    len_push  = rx_io.frame_end && !len_full;
    // A verdict needs a frame that has no verdict yet, counting a length pushed this cycle.
    stat_push = rx_io.crc_done &&
                ({1'b0, stat_cnt_q} < ({1'b0, len_cnt_q} + {{(DESC_AW + 1){1'b0}}, len_push}));
    start     = (state_q == StIdle) && (len_cnt_q != '0) && (stat_cnt_q != '0);
    rd_en     = (state_q != StIdle) && !rx_io.fifo_empty;

    wcnt_d = wcnt_q;
    if (rx_io.frame_end) begin
      wcnt_d = '0;
    end else if (rx_io.fifo_wr_en && !wsat) begin
      wcnt_d = wcnt_q + LenOne;
    end

    ovf_d = ovf_q | (rx_io.frame_end && len_full) | (rx_io.crc_done && !stat_push) |
            (wsat && (rx_io.fifo_wr_en || rx_io.frame_end));

    len_cnt_d = len_cnt_q;
    if (len_push && !start) begin
      len_cnt_d = len_cnt_q + CntOne;
    end else if (!len_push && start) begin
      len_cnt_d = len_cnt_q - CntOne;
    end

    stat_cnt_d = stat_cnt_q;
    if (stat_push && !start) begin
      stat_cnt_d = stat_cnt_q + CntOne;
    end else if (!stat_push && start) begin
      stat_cnt_d = stat_cnt_q - CntOne;
    end
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      wcnt_q     <= '0;
      ovf_q      <= 1'b0;
      len_wp_q   <= '0;
      len_rp_q   <= '0;
      len_cnt_q  <= '0;
      stat_wp_q  <= '0;
      stat_rp_q  <= '0;
      stat_cnt_q <= '0;
      stat_mem_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        len_mem_q[i] <= '0;
      end
    end else begin
      wcnt_q     <= wcnt_d;
      ovf_q      <= ovf_d;
      len_cnt_q  <= len_cnt_d;
      stat_cnt_q <= stat_cnt_d;
      if (len_push) begin
        len_mem_q[len_wp_q] <= frame_len;
        len_wp_q            <= len_wp_q + PtrOne;
      end
      if (stat_push) begin
        stat_mem_q[stat_wp_q] <= rx_io.crc_good;
        stat_wp_q             <= stat_wp_q + PtrOne;
      end
      if (start) begin
        len_rp_q  <= len_rp_q + PtrOne;
        stat_rp_q <= stat_rp_q + PtrOne;
      end
    end
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      rem_q        <= '0;
      cur_good_q   <= 1'b0;
      valid_q      <= 1'b0;
      good_frame_q <= 1'b0;
      bad_frame_q  <= 1'b0;
    end else begin
      valid_q      <= rd_en && (state_q == StRead);
      good_frame_q <= 1'b0;
      bad_frame_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            rem_q      <= len_mem_q[len_rp_q];
            cur_good_q <= stat_mem_q[stat_rp_q];
`ifdef RX_DROP_BAD_EN
            state_q    <= stat_mem_q[stat_rp_q] ? StRead : StDrop;
`else
            state_q    <= StRead;
`endif
          end
        end
        StRead: begin
          if (rd_en) begin
            rem_q <= rem_q - LenOne;
            if (rem_q == LenOne) begin
              state_q      <= StIdle;
              good_frame_q <= cur_good_q;
              bad_frame_q  <= !cur_good_q;
            end
          end
        end
        StDrop: begin
          if (rd_en) begin
            rem_q <= rem_q - LenOne;
            if (rem_q == LenOne) begin
              state_q     <= StIdle;
              bad_frame_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_io.fifo_rd_en    = rd_en;
  assign rx_io.rx_out_valid  = valid_q;
  assign rx_io.rx_good_frame = good_frame_q;
  assign rx_io.rx_bad_frame  = bad_frame_q;
  assign rx_io.desc_full     = len_full;
  assign rx_io.rx_overflow   = ovf_q;
endmodule

// File: tb/tb_rx_frame_release_ctrl.sv
// Bench for rx_frame_release_ctrl: directed scenarios plus random frames against a frame-level
// model (expected frame list and FIFO word count). Honours RX_DROP_BAD_EN if defined.
module tb_rx_frame_release_ctrl;
`ifdef RX_DROP_BAD_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  typedef struct {
    int len;
    bit good;
  } frame_t;

  logic rxclk = 1'b0;
  logic reset = 1'b1;

  rx_frame_release_ctrl_if bus ();

  rx_frame_release_ctrl #(.LEN_W(11), .DESC_AW(2)) dut (
    .rxclk(rxclk),
    .reset(reset),
    .rx_io(bus)
  );

  always #5 rxclk = ~rxclk;

  int     total = 0;
  int     bad = 0;
  frame_t exp_q[$];
  bit     pend_q[$];
  int     widx = 0, n_rd = 0, exp_rd = 0, n_valid = 0, n_goodp = 0, n_badp = 0, n_done = 0;
  int     words = 0;
  bit     force_empty = 1'b0, rand_mode = 1'b0;
  logic   wr_s = 1'b0, rd_s = 1'b0;
  frame_t f;
  bit     last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Data FIFO model: one word in per write strobe, one out per read strobe.
  assign bus.fifo_empty = (words == 0) || force_empty;
  always @(posedge rxclk or posedge reset) begin
    if (reset) words <= 0;
    else       words <= words + int'(wr_s) - int'(rd_s);
  end

  // Output monitor: each delivered frame must give len valid words with the end pulse on the last.
  always @(negedge rxclk) begin
    wr_s = bus.fifo_wr_en;
    rd_s = bus.fifo_rd_en;
    if (reset) begin
      exp_q.delete();
      widx = 0;
      n_rd = exp_rd;
    end else begin
      if (bus.fifo_rd_en) begin
        n_rd++;
        chk("rd_while_empty", bus.fifo_empty, 0);
      end
      if (bus.rx_out_valid)  n_valid++;
      if (bus.rx_good_frame) n_goodp++;
      if (bus.rx_bad_frame)  n_badp++;
      if (bus.rx_out_valid || bus.rx_good_frame || bus.rx_bad_frame) begin
        if (exp_q.size() == 0) begin
          chk("out_without_frame", {bus.rx_out_valid, bus.rx_good_frame, bus.rx_bad_frame}, 0);
        end else begin
          f = exp_q[0];
          if (DropEn && !f.good) begin
            chk("drop_valid", bus.rx_out_valid, 0);
            chk("drop_good", bus.rx_good_frame, 0);
            chk("drop_bad", bus.rx_bad_frame, 1);
            exp_rd += f.len;
            n_done++;
            void'(exp_q.pop_front());
          end else begin
            widx++;
            last = (widx == f.len);
            chk("word_valid", bus.rx_out_valid, 1);
            chk("good_pulse", bus.rx_good_frame, last && f.good);
            chk("bad_pulse", bus.rx_bad_frame, last && !f.good);
            if (last) begin
              exp_rd += f.len;
              n_done++;
              widx = 0;
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic tick(input bit wr, input bit fe, input bit cd, input bit cg);
    bus.fifo_wr_en = wr;
    bus.frame_end  = fe;
    bus.crc_done   = cd;
    bus.crc_good   = cg;
    if (rand_mode) force_empty = ($urandom_range(0, 4) == 0);
    @(posedge rxclk);
    #1;
    bus.fifo_wr_en = 1'b0;
    bus.frame_end  = 1'b0;
    bus.crc_done   = 1'b0;
    bus.crc_good   = 1'b0;
  endtask

  // One cycle that may also deliver the verdict of the oldest judged-pending frame.
  task automatic tick_v(input bit wr, input bit fe);
    bit cd = 1'b0;
    bit cg = 1'b0;
    if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
      cd = 1'b1;
      cg = pend_q.pop_front();
    end
    tick(wr, fe, cd, cg);
  endtask

  task automatic send_frame(input int len, input bit good, input bit acc, input bit rnd);
    for (int i = 0; i < len; i++) begin
      if (rnd) begin
        while ($urandom_range(0, 3) == 0) tick_v(1'b0, 1'b0);
        tick_v(1'b1, i == len - 1);
      end else begin
        tick(1'b1, i == len - 1, 1'b0, 1'b0);
      end
    end
    if (acc) begin
      exp_q.push_back('{len: len, good: good});
      pend_q.push_back(good);
    end
  endtask

  task automatic drain();
    int t = 0;
    bit g;
    while (exp_q.size() != 0 && t < 3000) begin
      if (pend_q.size() > 0) begin
        g = pend_q.pop_front();
        tick(1'b0, 1'b0, 1'b1, g);
      end else begin
        tick(1'b0, 1'b0, 1'b0, 1'b0);
      end
      t++;
    end
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("drain_left", exp_q.size(), 0);
    chk("rd_total", n_rd, exp_rd);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend_q.delete();
    force_empty = 1'b0;
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_outs_zero(input string pfx);
    chk({pfx, "_rd_en"}, bus.fifo_rd_en, 0);
    chk({pfx, "_valid"}, bus.rx_out_valid, 0);
    chk({pfx, "_good"}, bus.rx_good_frame, 0);
    chk({pfx, "_bad"}, bus.rx_bad_frame, 0);
    chk({pfx, "_desc_full"}, bus.desc_full, 0);
    chk({pfx, "_overflow"}, bus.rx_overflow, 0);
  endtask

  initial begin
    int b_rd, b_val, b_gp, b_bp, b_done, t;
    bus.fifo_wr_en = 1'b0;
    bus.frame_end  = 1'b0;
    bus.crc_done   = 1'b0;
    bus.crc_good   = 1'b0;
    repeat (2) @(posedge rxclk);
    #1;
    chk_outs_zero("in_reset");
    reset = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk_outs_zero("after_reset");

    // 1) single 8-word good frame, verdict a few cycles after frame_end
    b_val = n_valid; b_gp = n_goodp;
    send_frame(8, 1'b1, 1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    chk("t1_valid", n_valid - b_val, 8);
    chk("t1_good", n_goodp - b_gp, 1);

    // 2) 3-word good then 5-word bad, back to back
    b_val = n_valid; b_gp = n_goodp; b_bp = n_badp; b_rd = n_rd;
    send_frame(3, 1'b1, 1'b1, 1'b0);
    send_frame(5, 1'b0, 1'b1, 1'b0);
    drain();
    chk("t2_rd", n_rd - b_rd, 8);
    chk("t2_valid", n_valid - b_val, DropEn ? 3 : 8);
    chk("t2_good", n_goodp - b_gp, 1);
    chk("t2_bad", n_badp - b_bp, 1);

    // 3) 4-word bad then 2-word good
    b_val = n_valid; b_gp = n_goodp; b_bp = n_badp;
    send_frame(4, 1'b0, 1'b1, 1'b0);
    send_frame(2, 1'b1, 1'b1, 1'b0);
    drain();
    chk("t3_valid", n_valid - b_val, DropEn ? 2 : 6);
    chk("t3_good", n_goodp - b_gp, 1);
    chk("t3_bad", n_badp - b_bp, 1);

    // 4) five frames without verdicts: fifth overflows the length queue
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(2, 1'b1, 1'b1, 1'b0);
    chk("t4_full", bus.desc_full, 1);
    chk("t4_no_ovf_yet", bus.rx_overflow, 0);
    send_frame(2, 1'b1, 1'b0, 1'b0);
    chk("t4_ovf", bus.rx_overflow, 1);
    b_done = n_done;
    drain();
    chk("t4_frames", n_done - b_done, 4);
    chk("t4_leftover_words", words, 2);
    chk("t4_not_full", bus.desc_full, 0);
    do_reset();
    chk("t4_ovf_cleared", bus.rx_overflow, 0);

    // 5) FIFO empty for 3 cycles in the middle of a 6-word frame
    b_rd = n_rd; b_gp = n_goodp;
    send_frame(6, 1'b1, 1'b1, 1'b0);
    t = 0;
    while (pend_q.size() > 0) begin
      void'(pend_q.pop_front());
      tick(1'b0, 1'b0, 1'b1, 1'b1);
    end
    while (n_rd - b_rd < 2 && t < 100) begin
      @(negedge rxclk);
      #1;
      t++;
    end
    chk("t5_started", n_rd - b_rd >= 2, 1);
    @(posedge rxclk);
    #1;
    force_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge rxclk);
      chk("t5_stall_rd", bus.fifo_rd_en, 0);
    end
    @(posedge rxclk);
    #1;
    force_empty = 1'b0;
    drain();
    chk("t5_rd", n_rd - b_rd, 6);
    chk("t5_good", n_goodp - b_gp, 1);

    // 6) reset in the middle of a 6-word frame
    b_rd = n_rd;
    send_frame(6, 1'b1, 1'b1, 1'b0);
    void'(pend_q.pop_front());
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    t = 0;
    while (n_rd - b_rd < 3 && t < 100) begin
      @(negedge rxclk);
      #1;
      t++;
    end
    chk("t6_started", n_rd - b_rd >= 3, 1);
    @(posedge rxclk);
    #1;
    reset = 1'b1;
    #1;
    chk_outs_zero("t6_rst");
    do_reset();
    chk_outs_zero("t6_post");
    tick(1'b0, 1'b0, 1'b1, 1'b1);  // verdict with no frame queued
    chk("t6_stat_empty_ovf", bus.rx_overflow, 1);
    do_reset();
    b_gp = n_goodp; b_val = n_valid;
    send_frame(4, 1'b1, 1'b1, 1'b0);
    drain();
    chk("t6_valid", n_valid - b_val, 4);
    chk("t6_good", n_goodp - b_gp, 1);

    // Random frames, random verdict timing and FIFO stalls
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      t = 0;
      while (bus.desc_full && t < 200) begin
        tick_v(1'b0, 1'b0);
        t++;
      end
      chk("rnd_room", bus.desc_full, 0);
      send_frame($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end
    drain();
    rand_mode = 1'b0;
    force_empty = 1'b0;
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rnd_words", words, 0);
    chk("rnd_no_ovf", bus.rx_overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
